pid_cell: RTL and testbench

PID_CELL -- requirements
Module: pid_cell

---
 rtl/pid_pkg.sv | 22 ++
 rtl/sat_mul.sv | 32 +++
 rtl/pid_cell.sv | 190 +++++++++++++++++++
 tb/tb_pid_cell.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared constants for the PID cell: FSM encoding, fixed-point default and
// register-bank word positions.
package pid_pkg;

    localparam int FRAC_BITS_DEF = 16;

    localparam int WORD_SP = 0;
    localparam int WORD_KP = 1;
    localparam int WORD_KI = 2;
    localparam int WORD_KD = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_MUL_P = 3'd2,
        ST_MUL_I = 3'd3,
        ST_MUL_D = 3'd4,
        ST_SUM   = 3'd5,
        ST_OUT   = 3'd6
    } pid_state_e;

endpackage

// File: rtl/sat_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by the
// fractional bit count, saturated back to the word width.
module sat_mul #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] y
);

    localparam int W = DATA_WIDTH;

    logic signed [2*W-1:0] prod;
    logic signed [2*W-1:0] shifted;
    logic        [W:0]     upper;

    always_comb begin
        prod    = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        shifted = prod >>> FRAC_BITS;
        upper   = shifted[2*W-1:W-1];
        // In range only when every bit above the result word matches its sign bit
        if ((&upper) || !(|upper)) begin
            y = shifted[W-1:0];
        end else if (shifted[2*W-1]) begin
            y = {1'b1, {(W-1){1'b0}}};
        end else begin
            y = {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/pid_cell.sv
// Sequential fixed-point PID controller: one sample in, one control word out,
// with a single multiplier shared across the P, I and D terms.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a sample, or applying a deferred parameter load
// ST_ERR   | e = sat(sp - y)
// ST_MUL_P | p = kp * e
// ST_MUL_I | integ = clamp(integ + ki * e)
// ST_MUL_D | d = kd * sat(e - e_prev), e_prev = e
// ST_SUM   | m_data = clamp(p + integ + d)
// ST_OUT   | m_valid high until the consumer accepts
module pid_cell
    import pid_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter int                     DATA_SIZE  = 128,
    parameter int                     FRAC_BITS  = FRAC_BITS_DEF,
    parameter logic signed [DATA_WIDTH-1:0] OUT_MAX = 32'h7FFFFFFF,
    parameter logic signed [DATA_WIDTH-1:0] OUT_MIN = 32'h80000000
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_SIZE-1:0]  regs_in,
    input  logic                  param_en,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int W = DATA_WIDTH;

    pid_state_e state;
    logic       pending;

    logic signed [W-1:0] sp, kp, ki, kd;
    logic signed [W-1:0] y, e, e_prev, p, integ, d;

    logic signed [W-1:0] mul_a, mul_b, mul_y;
    logic signed [W:0]   err_wide, de_wide;
    logic signed [W+1:0] integ_wide, sum_wide;
    logic signed [W-1:0] err_sat, de_sat, integ_next, sum_clamped;

    function automatic logic signed [W-1:0] sat_full(input logic signed [W:0] v);
        if (v[W] == v[W-1]) begin
            return v[W-1:0];
        end else if (v[W]) begin
            return {1'b1, {(W-1){1'b0}}};
        end else begin
            return {1'b0, {(W-1){1'b1}}};
        end
    endfunction

    function automatic logic signed [W-1:0] clamp_out(input logic signed [W+1:0] v);
        if (v > $signed({{2{OUT_MAX[W-1]}}, OUT_MAX})) begin
            return OUT_MAX;
        end else if (v < $signed({{2{OUT_MIN[W-1]}}, OUT_MIN})) begin
            return OUT_MIN;
        end else begin
            return v[W-1:0];
        end
    endfunction

    always_comb begin
        err_wide    = $signed({sp[W-1], sp}) - $signed({y[W-1], y});
        err_sat     = sat_full(err_wide);
        de_wide     = $signed({e[W-1], e}) - $signed({e_prev[W-1], e_prev});
        de_sat      = sat_full(de_wide);
        integ_wide  = $signed({{2{integ[W-1]}}, integ}) + $signed({{2{mul_y[W-1]}}, mul_y});
        integ_next  = clamp_out(integ_wide);
        sum_wide    = $signed({{2{p[W-1]}}, p}) + $signed({{2{integ[W-1]}}, integ})
                    + $signed({{2{d[W-1]}}, d});
        sum_clamped = clamp_out(sum_wide);
    end

    always_comb begin
        mul_a = kp;
        mul_b = e;
        case (state)
            ST_MUL_I: mul_a = ki;
            ST_MUL_D: begin
                mul_a = kd;
                mul_b = de_sat;
            end
            default: ;
        endcase
    end

    sat_mul #(
        .DATA_WIDTH (W),
        .FRAC_BITS  (FRAC_BITS)
    ) u_sat_mul (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            busy    <= 1'b0;
            sp      <= '0;
            kp      <= '0;
            ki      <= '0;
            kd      <= '0;
            y       <= '0;
            e       <= '0;
            e_prev  <= '0;
            p       <= '0;
            integ   <= '0;
            d       <= '0;
        end else begin
            if (param_en && state != ST_IDLE) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        sp      <= regs_in[WORD_SP*W +: W];
                        kp      <= regs_in[WORD_KP*W +: W];
                        ki      <= regs_in[WORD_KI*W +: W];
                        kd      <= regs_in[WORD_KD*W +: W];
                        pending <= 1'b0;
                        s_ready <= 1'b1;
                    end else if (s_valid && s_ready) begin
                        // A strobe arriving with the sample waits so this sample sees the old gains
                        y       <= s_data;
                        pending <= param_en;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_ERR;
                    end else begin
                        if (param_en) begin
                            sp <= regs_in[WORD_SP*W +: W];
                            kp <= regs_in[WORD_KP*W +: W];
                            ki <= regs_in[WORD_KI*W +: W];
                            kd <= regs_in[WORD_KD*W +: W];
                        end
                        s_ready <= 1'b1;
                    end
                end
                ST_ERR: begin
                    e     <= err_sat;
                    state <= ST_MUL_P;
                end
                ST_MUL_P: begin
                    p     <= mul_y;
                    state <= ST_MUL_I;
                end
                ST_MUL_I: begin
                    integ <= integ_next;
                    state <= ST_MUL_D;
                end
                ST_MUL_D: begin
                    d      <= mul_y;
                    e_prev <= e;
                    state  <= ST_SUM;
                end
                ST_SUM: begin
                    m_data  <= sum_clamped;
                    m_valid <= 1'b1;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        s_ready <= !(pending || param_en);
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    m_valid <= 1'b0;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_cell.sv
// Directed bench for pid_cell: reset, P/I/D terms, saturation, deferred
// parameter loads, output backpressure and reset in mid-computation.
module tb_pid_cell;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b1;
    logic [127:0] regs_in = '0;
    logic         param_en = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic         busy;

    int n_checks = 0;
    int n_fail = 0;

    pid_cell dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .regs_in  (regs_in),
        .param_en (param_en),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic load_params(input logic [31:0] sp, input logic [31:0] kp,
                               input logic [31:0] ki, input logic [31:0] kd);
        regs_in  = {kd, ki, kp, sp};
        param_en = 1'b1;
        tick();
        param_en = 1'b0;
    endtask

    // Handshake at cycle 0; lat counts cycles until m_valid is seen.
    task automatic send_sample(input logic [31:0] yv, output logic [31:0] res, output int lat);
        int n;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        s_data  = yv;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 50) begin
            tick();
            lat++;
        end
        res     = m_data;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 aresetn = 1'b0;
        #2;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_checks++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_m_data got %h want 0", m_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        tick();
        aresetn = 1'b1;
        tick();
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_s_ready got %b want 1", s_ready); end
    endtask

    task automatic test_proportional();
        logic [31:0] res;
        int lat;
        do_reset();
        load_params(32'h0002_0000, 32'h0001_0000, 32'h0, 32'h0);
        send_sample(32'h0, res, lat);
        n_checks++; if (res !== 32'h0002_0000) begin n_fail++; $display("FAIL prop_data got %h want 00020000", res); end
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL prop_latency got %0d want 6", lat); end
    endtask

    task automatic test_integral();
        logic [31:0] res;
        int lat;
        logic [31:0] exp_tab [3];
        exp_tab = '{32'h0000_8000, 32'h0001_0000, 32'h0001_8000};
        do_reset();
        load_params(32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            send_sample(32'h0, res, lat);
            n_checks++;
            if (res !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL integ_%0d got %h want %h", i, res, exp_tab[i]);
            end
        end
    endtask

    task automatic test_derivative();
        logic [31:0] res;
        int lat;
        do_reset();
        load_params(32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000);
        send_sample(32'h0, res, lat);
        n_checks++; if (res !== 32'h0001_0000) begin n_fail++; $display("FAIL deriv_first got %h want 00010000", res); end
        send_sample(32'h0, res, lat);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL deriv_second got %h want 00000000", res); end
    endtask

    task automatic test_saturation();
        logic [31:0] res;
        int lat;
        do_reset();
        load_params(32'h03E8_0000, 32'h0064_0000, 32'h0, 32'h0);
        send_sample(32'h0, res, lat);
        n_checks++; if (res !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_pos got %h want 7fffffff", res); end
        load_params(32'hFC18_0000, 32'h0064_0000, 32'h0, 32'h0);
        send_sample(32'h0, res, lat);
        n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_neg got %h want 80000000", res); end
    endtask

    task automatic test_param_busy();
        logic [31:0] res;
        int lat;
        do_reset();
        load_params(32'h0002_0000, 32'h0001_0000, 32'h0, 32'h0);
        s_data  = 32'h0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        regs_in  = {32'h0, 32'h0, 32'h0002_0000, 32'h0002_0000};
        param_en = 1'b1;
        tick();
        param_en = 1'b0;
        lat = 3;
        while (!m_valid && lat < 50) begin
            tick();
            lat++;
        end
        n_checks++; if (lat != 6) begin n_fail++; $display("FAIL param_busy_latency got %0d want 6", lat); end
        n_checks++; if (m_data !== 32'h0002_0000) begin n_fail++; $display("FAIL param_busy_old_kp got %h want 00020000", m_data); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL param_busy_hold got s_ready=%b want 0", s_ready); end
        tick();
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL param_busy_release got s_ready=%b want 1", s_ready); end
        send_sample(32'h0, res, lat);
        n_checks++; if (res !== 32'h0004_0000) begin n_fail++; $display("FAIL param_busy_new_kp got %h want 00040000", res); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int n;
        bit data_bad;
        bit ready_bad;
        do_reset();
        load_params(32'h0002_0000, 32'h0001_0000, 32'h0, 32'h0);
        s_data  = 32'h0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        n = 1;
        while (!m_valid && n < 50) begin
            tick();
            n++;
        end
        held = m_data;
        data_bad = 1'b0;
        ready_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_data !== 32'h0002_0000 || m_valid !== 1'b1) data_bad = 1'b1;
            if (s_ready !== 1'b0) ready_bad = 1'b1;
            tick();
        end
        n_checks++; if (held !== 32'h0002_0000) begin n_fail++; $display("FAIL bp_data got %h want 00020000", held); end
        n_checks++; if (data_bad) begin n_fail++; $display("FAIL bp_stable got last=%h valid=%b want 00020000 valid=1", m_data, m_valid); end
        n_checks++; if (ready_bad) begin n_fail++; $display("FAIL bp_s_ready got 1 during backpressure want 0"); end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        int lat;
        bit saw_valid;
        do_reset();
        load_params(32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0);
        send_sample(32'h0, res, lat);
        n_checks++; if (res !== 32'h0000_8000) begin n_fail++; $display("FAIL rst_pre got %h want 00008000", res); end
        s_data  = 32'h0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        aresetn = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_outputs got busy=%b m_valid=%b s_ready=%b want 0 0 0", busy, m_valid, s_ready);
        end
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_release got s_ready=%b want 1", s_ready); end
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid !== 1'b0) saw_valid = 1'b1;
            tick();
        end
        n_checks++; if (saw_valid) begin n_fail++; $display("FAIL rst_mid_no_output got m_valid=1 want 0"); end
        load_params(32'h0001_0000, 32'h0, 32'h0000_8000, 32'h0);
        send_sample(32'h0, res, lat);
        n_checks++; if (res !== 32'h0000_8000) begin n_fail++; $display("FAIL rst_mid_integ_cleared got %h want 00008000", res); end
    endtask

    initial begin
        test_reset();
        test_proportional();
        test_integral();
        test_derivative();
        test_saturation();
        test_param_busy();
        test_backpressure();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
